mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single word-memory port (read address, write address, write data, byte strobes, read data) between the ice_risc_rv core and a second master such as a loader or debug port. It sits between the requesters and the memory in the top level, on the divided clock. It serialises accesses with a fixed 4-state transaction FSM and grants fairly by round-robin.

## Interface
- pAddrWidth, 32, width of all address ports
- iwClk  in  1  system clock; all state changes on rising edge
- iwnRst  in  1  asynchronous, active-low reset
- iwM0Req / iwM1Req  in  1  request from master 0 / 1; held high until its ack is seen
- iwM0Write / iwM1Write  in  1  1 = write, 0 = read
- iwM0Addr / iwM1Addr  in  pAddrWidth  byte address, word-aligned
- iwM0WData / iwM1WData  in  32  write data
- iwM0Wstrb / iwM1Wstrb  in  4  byte strobes; ignored for reads
- owM0Ack / owM1Ack  out  1  one-cycle completion pulse
- owM0RData / owM1RData  out  32  read data, valid while ack high, held until next read by that master
- owGrant  out  2  one-hot current owner, 00 in IDLE
- owMemReadAddr  out  pAddrWidth  to memory read address
- owMemWriteAddr  out  pAddrWidth  to memory write address
- owMemWriteData  out  32  to memory write data
- owMemWstrb  out  4  to memory byte strobes; nonzero only in ISSUE of a write
- iwMemReadData  in  32  memory read data, valid one cycle after read address

## Operation
- States: IDLE, ISSUE, RESP, ACK. Reset state IDLE.
- IDLE: if no request, stay. If exactly one request, grant it. If both request, grant the master not served last. The last-served pointer resets to "M1", so M0 wins the first tie. On grant, latch write, addr, wdata and wstrb of the winner into internal registers, set owGrant, and go to ISSUE.
- ISSUE: owMemReadAddr = owMemWriteAddr = latched addr. owMemWstrb = latched wstrb if write, else 0000. Go to RESP.
- RESP: address held, owMemWstrb = 0000. For a read, capture iwMemReadData into the winner's RData register at the end of RESP. For a write, the RData register is untouched. Go to ACK.
- ACK: winner's ack = 1, address held, owMemWstrb = 0000. Update the last-served pointer to the winner. Go to IDLE and clear owGrant.
- A request arriving or changing outside IDLE is ignored until the next IDLE. Latched fields are immune to input changes after the grant.
- Wstrb 0000 on a write is still a full transaction (ack issued, no memory change).
- Memory address outputs hold their last latched value in IDLE. They read 0 after reset.
- All outputs are registered or decoded from registered state only. There is no combinational path from iw* to ow*.

## Timing
- Reset (async, immediate): state IDLE, owGrant 00, owMemWstrb 0000, both acks 0, both RData 0, both addr outputs 0, owMemWriteData 0, pointer = M1.
- Reset asserted mid-transaction aborts it. If asserted during ISSUE, owMemWstrb drops to 0000 asynchronously, and the write may or may not commit depending on the memory edge. No ack is issued for the aborted transaction.
- Request sampled high at the edge ending IDLE cycle T:
  - T+1 ISSUE; a write commits at the end of T+1.
  - T+2 RESP; read data is sampled at the end of T+2.
  - T+3 ACK; ack high.
  - T+4 IDLE.
- Requester handshake: drop or change the request at the edge ending its ack cycle. A request still high in the IDLE cycle after ack is treated as a new transaction.
- Throughput: one transaction per 4 cycles. Back-to-back competing requests alternate M0, M1, M0, ...

## Test plan
- Reset, then M0 reads 0x10 (memory holds 0xDEADBEEF) -> owMemReadAddr=0x10 from T+1; owM0Ack pulses at T+3 only; owM0RData=0xDEADBEEF; owM1Ack stays 0.
- M1 writes 0x0000_00A5 to 0x20 with wstrb 0001 -> owMemWstrb=0001 in T+1 only. A following M0 read of 0x20 returns low byte 0xA5 with other bytes unchanged. owM1RData keeps its prior value.
- M0 and M1 request simultaneously and continuously for 4 transactions -> grants M0, M1, M0, M1; acks at cycles 3, 7, 11, 15 after the first sample; owGrant one-hot throughout.
- M0 changes addr from 0x10 to 0x30 during ISSUE -> the transaction uses 0x10; 0x30 is ignored unless still requested at the next IDLE.
- iwnRst pulled low during RESP of an M1 read -> state IDLE, all acks 0, owGrant 00, RData 0 immediately. After release, M0 wins a tie (pointer reset).
- Write with wstrb 0000 -> memory contents unchanged; ack still at T+3.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles every signal that the arbiter shares with its two requesters and
//   with the single-port word memory.
//
//   Requester side (per master 0/1):
//     iwMxReq, iwMxWrite, iwMxAddr, iwMxWData, iwMxWstrb   -> arbiter
//     owMxAck, owMxRData                                    <- arbiter
//   Memory side:
//     owMemReadAddr, owMemWriteAddr, owMemWriteData,
//     owMemWstrb                                            <- arbiter
//     iwMemReadData                                         -> arbiter
//   Ownership:
//     owGrant (one-hot current owner, 00 when idle)         <- arbiter
//
//   Modport slave is the arbiter's own view; modport master is the view of
//   whatever surrounds it (requesters plus memory).
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int pAddrWidth = 32
);
    logic                  iwM0Req;
    logic                  iwM0Write;
    logic [pAddrWidth-1:0] iwM0Addr;
    logic [31:0]           iwM0WData;
    logic [3:0]            iwM0Wstrb;
    logic                  owM0Ack;
    logic [31:0]           owM0RData;

    logic                  iwM1Req;
    logic                  iwM1Write;
    logic [pAddrWidth-1:0] iwM1Addr;
    logic [31:0]           iwM1WData;
    logic [3:0]            iwM1Wstrb;
    logic                  owM1Ack;
    logic [31:0]           owM1RData;

    logic [1:0]            owGrant;

    logic [pAddrWidth-1:0] owMemReadAddr;
    logic [pAddrWidth-1:0] owMemWriteAddr;
    logic [31:0]           owMemWriteData;
    logic [3:0]            owMemWstrb;
    logic [31:0]           iwMemReadData;

    modport slave (
        input  iwM0Req, iwM0Write, iwM0Addr, iwM0WData, iwM0Wstrb,
        input  iwM1Req, iwM1Write, iwM1Addr, iwM1WData, iwM1Wstrb,
        input  iwMemReadData,
        output owM0Ack, owM0RData, owM1Ack, owM1RData, owGrant,
        output owMemReadAddr, owMemWriteAddr, owMemWriteData, owMemWstrb
    );

    modport master (
        output iwM0Req, iwM0Write, iwM0Addr, iwM0WData, iwM0Wstrb,
        output iwM1Req, iwM1Write, iwM1Addr, iwM1WData, iwM1Wstrb,
        output iwMemReadData,
        input  owM0Ack, owM0RData, owM1Ack, owM1RData, owGrant,
        input  owMemReadAddr, owMemWriteAddr, owMemWriteData, owMemWstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one word-memory port between two masters (the core and a loader or
//   debug port). Every access runs through a fixed four-state transaction:
//   IDLE -> ISSUE -> RESP -> ACK -> IDLE. Simultaneous requests are resolved
//   round-robin against the master that was served last.
//
//   Ports:
//     iwClk   system clock, all state changes on the rising edge
//     iwnRst  asynchronous active-low reset
//     bus     mem_arbiter_if.slave: requester handshakes, read data returns,
//             one-hot grant and the memory address/data/strobe bus
//
//   Every output comes straight from a flop, so nothing on the iw* side can
//   ripple through to an ow* signal within a cycle.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int pAddrWidth = 32
) (
    input  logic         iwClk,
    input  logic         iwnRst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t                state_q;
    logic [1:0]            grant_q;
    logic                  write_q;
    logic [pAddrWidth-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            memWstrb_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic [31:0]           rdata0_q;
    logic [31:0]           rdata1_q;
    logic                  lastM1_q;
    logic                  pickM0;

    // M0 wins when it is the only requester, or on a tie when M1 was the
    // last one served. Only meaningful while at least one request is high.
    always_comb begin
        pickM0 = bus.iwM0Req & (~bus.iwM1Req | lastM1_q);
    end

    // Transaction FSM with all outputs registered. The strobes are loaded on
    // the grant edge so they are live exactly during ISSUE, and the acks are
    // loaded on the edge leaving RESP so they are live exactly during ACK.
    // The latched address stays put in IDLE, which keeps the memory address
    // outputs stable between transactions.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            memWstrb_q <= 4'h0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= 32'h0;
            rdata1_q   <= 32'h0;
            lastM1_q   <= 1'b1;
        end else begin
            memWstrb_q <= 4'h0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.iwM0Req || bus.iwM1Req) begin
                        if (pickM0) begin
                            grant_q    <= 2'b01;
                            write_q    <= bus.iwM0Write;
                            addr_q     <= bus.iwM0Addr;
                            wdata_q    <= bus.iwM0WData;
                            memWstrb_q <= bus.iwM0Write ? bus.iwM0Wstrb : 4'h0;
                        end else begin
                            grant_q    <= 2'b10;
                            write_q    <= bus.iwM1Write;
                            addr_q     <= bus.iwM1Addr;
                            wdata_q    <= bus.iwM1WData;
                            memWstrb_q <= bus.iwM1Write ? bus.iwM1Wstrb : 4'h0;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= RESP;
                end
                RESP: begin
                    // Memory data for the address shown in ISSUE is valid now.
                    if (!write_q) begin
                        if (grant_q[0]) begin
                            rdata0_q <= bus.iwMemReadData;
                        end else begin
                            rdata1_q <= bus.iwMemReadData;
                        end
                    end
                    ack0_q  <= grant_q[0];
                    ack1_q  <= grant_q[1];
                    state_q <= ACK;
                end
                ACK: begin
                    lastM1_q <= grant_q[1];
                    grant_q  <= 2'b00;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.owGrant        = grant_q;
    assign bus.owM0Ack        = ack0_q;
    assign bus.owM1Ack        = ack1_q;
    assign bus.owM0RData      = rdata0_q;
    assign bus.owM1RData      = rdata1_q;
    assign bus.owMemReadAddr  = addr_q;
    assign bus.owMemWriteAddr = addr_q;
    assign bus.owMemWriteData = wdata_q;
    assign bus.owMemWstrb     = memWstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Drives mem_arbiter through a table of single transactions against a small
//   16-word byte-strobed memory, then runs hand-written sequences for the
//   round-robin tie, address changes after grant and reset mid-transaction.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    typedef struct {
        logic        isM1;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] expRData;
    } vec_t;

    logic clock;
    logic rstN;
    int   testsRun;
    int   testsFailed;
    logic [31:0] expRd0;
    logic [31:0] expRd1;
    logic [31:0] mem [0:15];
    vec_t vectors [8];

    mem_arbiter_if #(.pAddrWidth(32)) bus ();

    mem_arbiter #(.pAddrWidth(32)) dut (
        .iwClk  (clock),
        .iwnRst (rstN),
        .bus    (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory: strobed writes and a registered read, so data for the
    // address presented in one cycle appears in the next. Reset reloads the
    // known contents the expected values are computed from.
    always @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 32'h0;
            end
            mem[4]  <= 32'hDEADBEEF;
            mem[8]  <= 32'h11223344;
            mem[12] <= 32'hCAFEF00D;
            bus.iwMemReadData <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bus.owMemWstrb[b]) begin
                    mem[bus.owMemWriteAddr[5:2]][8*b +: 8] <= bus.owMemWriteData[8*b +: 8];
                end
            end
            bus.iwMemReadData <= mem[bus.owMemReadAddr[5:2]];
        end
    end

    // Compares one observed value with its hand-computed expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Clears every requester input.
    task automatic idleInputs();
        bus.iwM0Req   = 1'b0;
        bus.iwM0Write = 1'b0;
        bus.iwM0Addr  = 32'h0;
        bus.iwM0WData = 32'h0;
        bus.iwM0Wstrb = 4'h0;
        bus.iwM1Req   = 1'b0;
        bus.iwM1Write = 1'b0;
        bus.iwM1Addr  = 32'h0;
        bus.iwM1WData = 32'h0;
        bus.iwM1Wstrb = 4'h0;
    endtask

    // Pulses reset across one rising edge, starting and ending on a negedge.
    task automatic pulseReset();
        @(negedge clock);
        rstN = 1'b0;
        @(negedge clock);
        rstN = 1'b1;
        expRd0 = 32'h0;
        expRd1 = 32'h0;
    endtask

    // Runs one complete transaction from a single master, starting at a
    // negedge inside IDLE and returning at the negedge of the following IDLE.
    task automatic applyStimulus(input vec_t v);
        logic [1:0]  expGrant;
        logic [31:0] expWstrb;
        expGrant = v.isM1 ? 2'b10 : 2'b01;
        expWstrb = v.write ? 32'(v.wstrb) : 32'h0;
        if (v.isM1) begin
            bus.iwM1Req   = 1'b1;
            bus.iwM1Write = v.write;
            bus.iwM1Addr  = v.addr;
            bus.iwM1WData = v.wdata;
            bus.iwM1Wstrb = v.wstrb;
        end else begin
            bus.iwM0Req   = 1'b1;
            bus.iwM0Write = v.write;
            bus.iwM0Addr  = v.addr;
            bus.iwM0WData = v.wdata;
            bus.iwM0Wstrb = v.wstrb;
        end

        @(negedge clock);
        checkOutput("issue grant", 32'(bus.owGrant), 32'(expGrant));
        checkOutput("issue read addr", bus.owMemReadAddr, v.addr);
        checkOutput("issue write addr", bus.owMemWriteAddr, v.addr);
        checkOutput("issue wstrb", 32'(bus.owMemWstrb), expWstrb);
        if (v.write) begin
            checkOutput("issue wdata", bus.owMemWriteData, v.wdata);
        end
        checkOutput("issue acks", 32'({bus.owM1Ack, bus.owM0Ack}), 32'h0);

        @(negedge clock);
        checkOutput("resp wstrb", 32'(bus.owMemWstrb), 32'h0);
        checkOutput("resp acks", 32'({bus.owM1Ack, bus.owM0Ack}), 32'h0);
        checkOutput("resp read addr", bus.owMemReadAddr, v.addr);

        @(negedge clock);
        if (!v.write) begin
            if (v.isM1) expRd1 = v.expRData;
            else        expRd0 = v.expRData;
        end
        checkOutput("ack acks", 32'({bus.owM1Ack, bus.owM0Ack}), 32'(expGrant));
        checkOutput("ack wstrb", 32'(bus.owMemWstrb), 32'h0);
        checkOutput("ack m0 rdata", bus.owM0RData, expRd0);
        checkOutput("ack m1 rdata", bus.owM1RData, expRd1);
        idleInputs();

        @(negedge clock);
        checkOutput("idle grant", 32'(bus.owGrant), 32'h0);
        checkOutput("idle acks", 32'({bus.owM1Ack, bus.owM0Ack}), 32'h0);
        checkOutput("idle addr hold", bus.owMemReadAddr, v.addr);
    endtask

    initial begin
        logic [3:0] expFlags;
        testsRun    = 0;
        testsFailed = 0;
        expRd0      = 32'h0;
        expRd1      = 32'h0;
        rstN        = 1'b0;
        idleInputs();

        //                  isM1  wr    addr   wdata         wstrb  expRData
        vectors[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF};
        vectors[1] = '{1'b1, 1'b1, 32'h20, 32'h000000A5, 4'h1, 32'h0};
        vectors[2] = '{1'b0, 1'b0, 32'h20, 32'h0,        4'h0, 32'h112233A5};
        vectors[3] = '{1'b1, 1'b0, 32'h30, 32'h0,        4'h0, 32'hCAFEF00D};
        vectors[4] = '{1'b1, 1'b1, 32'h30, 32'h55667788, 4'h0, 32'h0};
        vectors[5] = '{1'b0, 1'b0, 32'h30, 32'h0,        4'h0, 32'hCAFEF00D};
        vectors[6] = '{1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'hC, 32'h0};
        vectors[7] = '{1'b1, 1'b0, 32'h10, 32'h0,        4'h0, 32'hAABBBEEF};

        // Reset state.
        @(negedge clock);
        @(negedge clock);
        rstN = 1'b1;
        checkOutput("reset grant", 32'(bus.owGrant), 32'h0);
        checkOutput("reset acks", 32'({bus.owM1Ack, bus.owM0Ack}), 32'h0);
        checkOutput("reset m0 rdata", bus.owM0RData, 32'h0);
        checkOutput("reset m1 rdata", bus.owM1RData, 32'h0);
        checkOutput("reset read addr", bus.owMemReadAddr, 32'h0);
        checkOutput("reset write addr", bus.owMemWriteAddr, 32'h0);
        checkOutput("reset wdata", bus.owMemWriteData, 32'h0);
        checkOutput("reset wstrb", 32'(bus.owMemWstrb), 32'h0);

        // Single transactions from the table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i]);
        end

        // Continuous tie after reset: M0, M1, M0, M1 with acks on cycles
        // 3, 7, 11, 15 after the first sampling edge.
        pulseReset();
        bus.iwM0Req  = 1'b1;
        bus.iwM0Addr = 32'h10;
        bus.iwM1Req  = 1'b1;
        bus.iwM1Addr = 32'h30;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            case (k)
                1, 2, 9, 10:   expFlags = 4'b0100;
                3, 11:         expFlags = 4'b0110;
                5, 6, 13, 14:  expFlags = 4'b1000;
                7, 15:         expFlags = 4'b1001;
                default:       expFlags = 4'b0000;
            endcase
            checkOutput($sformatf("tie cycle %0d grant/ack0/ack1", k),
                        32'({bus.owGrant, bus.owM0Ack, bus.owM1Ack}), 32'(expFlags));
        end
        idleInputs();
        checkOutput("tie m0 rdata", bus.owM0RData, 32'hDEADBEEF);
        checkOutput("tie m1 rdata", bus.owM1RData, 32'hCAFEF00D);
        @(negedge clock);
        checkOutput("tie idle grant", 32'(bus.owGrant), 32'h0);

        // Address changed after grant must not affect the transaction.
        bus.iwM0Req  = 1'b1;
        bus.iwM0Addr = 32'h10;
        @(negedge clock);
        bus.iwM0Addr = 32'h30;
        checkOutput("latch issue addr", bus.owMemReadAddr, 32'h10);
        @(negedge clock);
        checkOutput("latch resp addr", bus.owMemReadAddr, 32'h10);
        @(negedge clock);
        checkOutput("latch ack", 32'(bus.owM0Ack), 32'h1);
        checkOutput("latch rdata", bus.owM0RData, 32'hDEADBEEF);
        idleInputs();
        @(negedge clock);

        // Reset during RESP of an M1 read aborts it and clears everything.
        bus.iwM1Req  = 1'b1;
        bus.iwM1Addr = 32'h30;
        @(negedge clock);
        @(negedge clock);
        checkOutput("abort pre grant", 32'(bus.owGrant), 32'h2);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("abort grant", 32'(bus.owGrant), 32'h0);
        checkOutput("abort acks", 32'({bus.owM1Ack, bus.owM0Ack}), 32'h0);
        checkOutput("abort m0 rdata", bus.owM0RData, 32'h0);
        checkOutput("abort m1 rdata", bus.owM1RData, 32'h0);
        checkOutput("abort addr", bus.owMemReadAddr, 32'h0);
        idleInputs();
        @(negedge clock);
        rstN = 1'b1;
        checkOutput("abort no ack", 32'({bus.owM1Ack, bus.owM0Ack}), 32'h0);

        // Pointer reset: M0 wins the first tie after release.
        bus.iwM0Req  = 1'b1;
        bus.iwM0Addr = 32'h10;
        bus.iwM1Req  = 1'b1;
        bus.iwM1Addr = 32'h30;
        @(negedge clock);
        checkOutput("post reset tie grant", 32'(bus.owGrant), 32'h1);
        @(negedge clock);
        @(negedge clock);
        checkOutput("post reset tie acks", 32'({bus.owM1Ack, bus.owM0Ack}), 32'h1);
        idleInputs();
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
